// File: rtl/lbist_misr.sv
// LBIST multiple-input signature register with pattern-count/check FSM.
// Compacts NUM_PATTERNS response words into a signature, then compares it with GOLDEN.
module lbist_misr #(
    parameter int unsigned  W            = 21,
    parameter int unsigned  NUM_PATTERNS = 1024,
    parameter logic [W-1:0] POLY         = 21'h5,
    parameter logic [W-1:0] SEED         = 21'h0,
    parameter logic [W-1:0] GOLDEN       = 21'h0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic                                  resp_valid,
    input  logic [W-1:0]                          resp_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  pass,
    output logic [W-1:0]                          signature,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]     pattern_cnt
);

    localparam int unsigned     CW       = $clog2(NUM_PATTERNS + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(NUM_PATTERNS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(NUM_PATTERNS - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    sig_q, sig_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    // One MISR step: shift toward bit 0, feedback from bit 0 into the MSB and the POLY taps.
    function automatic logic [W-1:0] misr_next(input logic [W-1:0] sig,
                                               input logic [W-1:0] resp);
        logic [W-1:0] nxt;
        logic         fb;
        fb        = sig[0];
        nxt[W-1]  = fb ^ resp[W-1];
        for (int i = 0; i < int'(W) - 1; i++) begin
            nxt[i] = sig[i+1] ^ resp[i] ^ (POLY[i] & fb);
        end
        return nxt;
    endfunction

    // Next-state, signature, counter and result computation.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        sig_d   = SEED;
                        cnt_d   = {CW{1'b0}};
                        pass_d  = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    if (resp_valid) begin
                        sig_d = misr_next(sig_q, resp_data);
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end else begin
                            cnt_d = cnt_q;
                        end
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_CHECK: begin
                    pass_d  = (sig_q == GOLDEN);
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // Status flags follow the state being entered so they are valid straight off the flops.
        busy_d = (state_d == ST_RUN) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign signature   = sig_q;
    assign pattern_cnt = cnt_q;

endmodule

// File: tb/tb_lbist_misr.sv
// Self-checking bench for lbist_misr: directed scenarios plus randomized runs on three instances,
// a behavioural MISR model and a done-triggered scoreboard.
module tb_lbist_misr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_x, abort_x, valid_x;
    logic [3:0] data_x;
    logic       start_y, abort_y, valid_y;
    logic [7:0] data_y;

    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
    logic [3:0] sig_a, sig_b;
    logic [1:0] cnt_a, cnt_b;
    logic [7:0] sig_c;
    logic [2:0] cnt_c;

    lbist_misr #(.W(4), .NUM_PATTERNS(2), .POLY(4'b1001), .SEED(4'h0), .GOLDEN(4'h9)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_x), .abort(abort_x), .resp_valid(valid_x),
        .resp_data(data_x), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a),
        .pattern_cnt(cnt_a));

    lbist_misr #(.W(4), .NUM_PATTERNS(2), .POLY(4'b1001), .SEED(4'h0), .GOLDEN(4'hA)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_x), .abort(abort_x), .resp_valid(valid_x),
        .resp_data(data_x), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b),
        .pattern_cnt(cnt_b));

    lbist_misr #(.W(8), .NUM_PATTERNS(5), .POLY(8'h1D), .SEED(8'hA5), .GOLDEN(8'h3C)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_y), .abort(abort_y), .resp_valid(valid_y),
        .resp_data(data_y), .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c),
        .pattern_cnt(cnt_c));

    // Model configuration per instance (a, b, c).
    int m_w[3]    = '{4, 4, 8};
    int m_np[3]   = '{2, 2, 5};
    int m_poly[3] = '{9, 9, 'h1D};
    int m_seed[3] = '{0, 0, 'hA5};
    int m_gold[3] = '{9, 'hA, 'h3C};

    // Model state: collecting words, one-cycle compare pending, result reported.
    bit coll[3], pend[3], dn[3], ps[3];
    int msig[3], mcnt[3];
    bit dprev[3];

    typedef struct { int sig; int pass; int cyc; } exp_t;
    exp_t q0[$], q1[$], q2[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int taps_of(int i);
        int top;
        top = 1 << (m_w[i] - 1);
        return (m_poly[i] & (top - 1)) | top;
    endfunction

    // Signature as arithmetic: halve, add the word, and fold the dropped LSB back through the taps.
    function automatic int misr_ref(int i, int s, int r);
        int mask;
        mask = (1 << m_w[i]) - 1;
        return ((s >> 1) ^ (r & mask) ^ (((s & 1) != 0) ? taps_of(i) : 0)) & mask;
    endfunction

    // Word that drives the signature of instance i onto value g in one step.
    function automatic int target_word(int i, int g);
        int s;
        s = msig[i];
        return g ^ (s >> 1) ^ (((s & 1) != 0) ? taps_of(i) : 0);
    endfunction

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(int i, exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            coll[i] = 1'b0; pend[i] = 1'b0; dn[i] = 1'b0; ps[i] = 1'b0;
            msig[i] = m_seed[i]; mcnt[i] = 0;
        end
        q0.delete(); q1.delete(); q2.delete();
    endtask

    task automatic model_step(int i, bit st, bit ab, bit v, int d);
        exp_t e;
        if (ab) begin
            coll[i] = 1'b0; pend[i] = 1'b0; dn[i] = 1'b0; ps[i] = 1'b0; mcnt[i] = 0;
        end else if (pend[i]) begin
            pend[i] = 1'b0; dn[i] = 1'b1; ps[i] = (msig[i] == m_gold[i]);
            e.sig = msig[i]; e.pass = ps[i]; e.cyc = cyc + 1;
            push(i, e);
        end else if (st && !coll[i]) begin
            coll[i] = 1'b1; dn[i] = 1'b0; ps[i] = 1'b0; msig[i] = m_seed[i]; mcnt[i] = 0;
        end else if (coll[i] && v) begin
            msig[i] = misr_ref(i, msig[i], d);
            mcnt[i]++;
            if (mcnt[i] == m_np[i]) begin
                coll[i] = 1'b0; pend[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check("sig_a", sig_a, msig[0]);  check("cnt_a", cnt_a, mcnt[0]);
        check("busy_a", busy_a, coll[0] | pend[0]);
        check("done_a", done_a, dn[0]);  check("pass_a", pass_a, ps[0]);
        check("sig_b", sig_b, msig[1]);  check("pass_b", pass_b, ps[1]);
        check("done_b", done_b, dn[1]);
        check("sig_c", sig_c, msig[2]);  check("cnt_c", cnt_c, mcnt[2]);
        check("busy_c", busy_c, coll[2] | pend[2]);
        check("done_c", done_c, dn[2]);  check("pass_c", pass_c, ps[2]);
    endtask

    // One clock of stimulus: update the model, let the DUT take the edge, compare, release pulses.
    task automatic cycle();
        model_step(0, start_x, abort_x, valid_x, data_x);
        model_step(1, start_x, abort_x, valid_x, data_x);
        model_step(2, start_y, abort_y, valid_y, data_y);
        @(negedge clk);
        check_all();
        start_x = 1'b0; abort_x = 1'b0; valid_x = 1'b0; data_x = 4'($urandom);
        start_y = 1'b0; abort_y = 1'b0; valid_y = 1'b0; data_y = 8'($urandom);
    endtask

    task automatic word_x(logic [3:0] d);
        valid_x = 1'b1; data_x = d;
        cycle();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_sig_a", sig_a, 0); check("rst_cnt_a", cnt_a, 0);
        check("rst_busy_a", busy_a, 0); check("rst_done_a", done_a, 0);
        check("rst_pass_a", pass_a, 0); check("rst_sig_c", sig_c, 'hA5);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every rising done pops the expected result for that instance.
    task automatic mon(int i, logic d, int s, logic p);
        exp_t e;
        int   n;
        if (d && !dprev[i]) begin
            n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
            if (n == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected_done_%0d: got done=1 expected no result pending", i);
            end else begin
                case (i)
                    0: e = q0.pop_front();
                    1: e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                check($sformatf("sb_sig_%0d", i), s, e.sig);
                check($sformatf("sb_pass_%0d", i), p, e.pass);
                check($sformatf("sb_latency_%0d", i), cyc, e.cyc);
            end
        end
        dprev[i] = d;
    endtask

    always @(negedge clk) begin
        mon(0, done_a, sig_a, pass_a);
        mon(1, done_b, sig_b, pass_b);
        mon(2, done_c, sig_c, pass_c);
    end

    initial begin
        rst_n = 1'b0;
        start_x = 1'b0; abort_x = 1'b0; valid_x = 1'b0; data_x = 4'h0;
        start_y = 1'b0; abort_y = 1'b0; valid_y = 1'b0; data_y = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Golden pass on a, fail on b.
        start_x = 1'b1; cycle();
        word_x(4'h1); check("s2_sig1", sig_a, 4'h1);
        word_x(4'h0); check("s2_sig2", sig_a, 4'h9); check("s2_not_done_yet", done_a, 0);
        cycle();
        check("s2_done", done_a, 1); check("s2_pass", pass_a, 1);
        check("s3_pass", pass_b, 0); check("s3_sig", sig_b, 4'h9);
        word_x(4'hF); check("done_frozen_sig", sig_a, 4'h9);

        // Restart from DONE.
        start_x = 1'b1; cycle();
        check("s6_done_clr", done_a, 0); check("s6_sig_seed", sig_a, 0); check("s6_cnt", cnt_a, 0);
        word_x(4'h1); word_x(4'h0); cycle();
        check("s6_pass", pass_a, 1);

        // Gaps between words.
        start_x = 1'b1; cycle();
        word_x(4'h1);
        repeat (5) cycle();
        check("s4_gap_sig", sig_a, 4'h1); check("s4_gap_cnt", cnt_a, 1);
        word_x(4'h0); cycle();
        check("s4_pass", pass_a, 1); check("s4_done", done_a, 1);

        // Abort together with start.
        start_x = 1'b1; cycle();
        word_x(4'h1);
        start_x = 1'b1; abort_x = 1'b1; cycle();
        check("s5_cnt", cnt_a, 0); check("s5_done", done_a, 0);
        check("s5_sig", sig_a, 4'h1); check("s5_busy", busy_a, 0);
        word_x(4'h7); check("idle_frozen_sig", sig_a, 4'h1);

        // Reset mid-run.
        start_x = 1'b1; cycle();
        word_x(4'h3);
        do_reset();
        check("s1_sig", sig_a, 0); check("s1_busy", busy_a, 0);

        // Randomized runs on both input groups, occasionally steering the last word onto GOLDEN.
        for (int n = 0; n < 1500; n++) begin
            start_x = ($urandom_range(0, 7) == 0);
            abort_x = ($urandom_range(0, 59) == 0);
            valid_x = 1'($urandom_range(0, 1));
            data_x  = 4'($urandom);
            if (coll[0] && mcnt[0] == 1 && $urandom_range(0, 2) == 0) begin
                valid_x = 1'b1;
                data_x  = 4'(target_word(0, m_gold[$urandom_range(0, 1)]));
            end
            start_y = ($urandom_range(0, 9) == 0);
            abort_y = ($urandom_range(0, 79) == 0);
            valid_y = 1'($urandom_range(0, 1));
            data_y  = 8'($urandom);
            if (coll[2] && mcnt[2] == 4 && $urandom_range(0, 2) == 0) begin
                valid_y = 1'b1;
                data_y  = 8'(target_word(2, m_gold[2]));
            end
            cycle();
            if (n == 700) do_reset();
        end

        @(negedge clk);
        #1;
        check("sb_q0_drained", q0.size(), 0);
        check("sb_q1_drained", q1.size(), 0);
        check("sb_q2_drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
